// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC operand loader datapath front end.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int OP_W_DEF    = 32;
  localparam int DIG_W_DEF   = 4;
  localparam int NUM_OPS_DEF = 5;

  localparam int OP_PX    = 0;
  localparam int OP_PY    = 1;
  localparam int OP_PRIME = 2;
  localparam int OP_A     = 3;
  localparam int OP_K     = 4;

endpackage

// File: rtl/digit_shift_reg.sv
// Single OP_W-bit operand register: synchronous clear, or write one DIG_W digit at a digit index.
module digit_shift_reg #(
  parameter int OP_W  = 32,
  parameter int DIG_W = 4,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [DIG_W-1:0] i_digit,
  output logic [OP_W-1:0]  o_q
);

  logic [OP_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_wr) begin
      r_q[i_idx*DIG_W +: DIG_W] <= i_digit;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ecc_operand_loader.sv
// Digit-serial deserializer collecting NUM_OPS operands with a done/ack handshake.
// Build option: define LOADER_MSB_FIRST_EN for most-significant-digit-first arrival.
module ecc_operand_loader
  import ecc_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int DIG_W   = DIG_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF,
  localparam int BEATS  = OP_W / DIG_W,
  localparam int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic [NUM_OPS*DIG_W-1:0] i_digits,
  input  logic                     i_ack,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_load_done,
  output logic [CNT_W-1:0]         o_beat_cnt,
  output logic [NUM_OPS*OP_W-1:0]  o_operands
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_idx;
  logic             w_clr;
  logic             w_wr;

  // Abort outranks a simultaneous valid beat, so the write is masked by it.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_wr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_clr  = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        if (i_abort) begin
          w_clr  = 1'b1;
          w_next = IDLE;
        end else if (i_valid) begin
          w_wr = 1'b1;
          if (r_cnt == CNT_W'(BEATS - 1)) w_next = HOLD;
        end
      end
      HOLD: begin
        if (i_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr)     r_cnt <= '0;
      else if (w_wr) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef LOADER_MSB_FIRST_EN
  assign w_idx = CNT_W'(BEATS - 1) - r_cnt;
`else
  assign w_idx = r_cnt;
`endif

  for (genvar j = 0; j < NUM_OPS; j++) begin : g_op
    digit_shift_reg #(
      .OP_W  (OP_W),
      .DIG_W (DIG_W),
      .IDX_W (CNT_W)
    ) u_reg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_clr),
      .i_wr    (w_wr),
      .i_idx   (w_idx),
      .i_digit (i_digits[j*DIG_W +: DIG_W]),
      .o_q     (o_operands[j*OP_W +: OP_W])
    );
  end

  assign o_busy      = (r_state == LOAD);
  assign o_load_done = (r_state == HOLD);
  assign o_beat_cnt  = r_cnt;

endmodule

// File: tb/tb_ecc_operand_loader.sv
// Directed self-checking bench for ecc_operand_loader (default and 8/8/2 configurations).
module tb_ecc_operand_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, valid, ack, abort;
  logic [19:0]  digits;
  logic         busy, done;
  logic [3:0]   cnt;
  logic [159:0] ops;

  logic         g_start, g_valid, g_ack, g_abort;
  logic [15:0]  g_digits;
  logic         g_busy, g_done;
  logic [0:0]   g_cnt;
  logic [15:0]  g_ops;

  int checks = 0;
  int errors = 0;

  logic [159:0] exp_a, exp_b;

  always #5 clk = ~clk;

  ecc_operand_loader #(.OP_W(32), .DIG_W(4), .NUM_OPS(5)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_digits(digits), .i_ack(ack), .i_abort(abort),
    .o_busy(busy), .o_load_done(done), .o_beat_cnt(cnt), .o_operands(ops)
  );

  ecc_operand_loader #(.OP_W(8), .DIG_W(8), .NUM_OPS(2)) u_gen (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(g_start), .i_valid(g_valid),
    .i_digits(g_digits), .i_ack(g_ack), .i_abort(g_abort),
    .o_busy(g_busy), .o_load_done(g_done), .o_beat_cnt(g_cnt), .o_operands(g_ops)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; valid = 1'b0; ack = 1'b0; abort = 1'b0; digits = '0;
    g_start = 1'b0; g_valid = 1'b0; g_ack = 1'b0; g_abort = 1'b0; g_digits = '0;
  endtask

  initial begin
`ifdef LOADER_MSB_FIRST_EN
    exp_a = {{4{32'hFFFFFFFF}}, 32'h12345678};
    exp_b = {{4{32'hAAAAAAAA}}, 32'h87654321};
`else
    exp_a = {{4{32'hFFFFFFFF}}, 32'h87654321};
    exp_b = {{4{32'hAAAAAAAA}}, 32'h12345678};
`endif
    idle_inputs();
    rst_n = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ops", ops, 0);
    rst_n = 1'b1;
    tick();

    // Basic load; valid in the start cycle must be ignored
    start = 1'b1; valid = 1'b1; digits = 20'h12345;
    tick();
    chk("start_busy", busy, 1);
    chk("start_cnt", cnt, 0);
    chk("start_ops", ops, 0);
    start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      digits = {16'hFFFF, 4'(b + 1)};
      tick();
      if (b == 6) begin
        chk("beat7_done", done, 0);
        chk("beat7_cnt", cnt, 7);
      end
    end
    valid = 1'b0;
    chk("basic_done", done, 1);
    chk("basic_busy", busy, 0);
    chk("basic_cnt", cnt, 8);
    chk("basic_ops", ops, exp_a);
    start = 1'b1; valid = 1'b1; abort = 1'b1; digits = 20'h00000;
    tick();
    tick();
    start = 1'b0; valid = 1'b0; abort = 1'b0;
    chk("hold_done", done, 1);
    chk("hold_ops", ops, exp_a);
    chk("hold_cnt", cnt, 8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_done", done, 0);
    chk("ack_busy", busy, 0);
    chk("ack_ops_kept", ops, exp_a);
    chk("ack_cnt_kept", cnt, 8);

    // Stalled load with ignored start/ack during LOAD; 12 cycles start-to-done
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_clr_ops", ops, 0);
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        valid = 1'b0; start = 1'b1; ack = 1'b1;
        tick(); tick(); tick();
        start = 1'b0; ack = 1'b0;
        chk("stall_cnt", cnt, 4);
        chk("stall_busy", busy, 1);
      end
      valid = 1'b1;
      digits = {16'hFFFF, 4'(b + 1)};
      tick();
      if (b == 6) chk("stall_not_done_11", done, 0);
    end
    valid = 1'b0;
    chk("stall_done_12", done, 1);
    chk("stall_ops", ops, exp_a);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Abort on beat 5 with a valid beat present
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      valid = 1'b1; digits = {16'hFFFF, 4'(b + 1)};
      tick();
    end
    abort = 1'b1; digits = 20'h55555;
    tick();
    abort = 1'b0; valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", cnt, 0);
    chk("abort_ops", ops, 0);
    valid = 1'b1; digits = 20'h77777;
    tick(); tick();
    valid = 1'b0;
    chk("abort_idle_done", done, 0);
    chk("abort_idle_cnt", cnt, 0);

    // Asynchronous reset during beat 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      valid = 1'b1; digits = {16'hAAAA, 4'(8 - b)};
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_ops", ops, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      valid = 1'b1; digits = {16'hAAAA, 4'(8 - b)};
      tick();
    end
    valid = 1'b0;
    chk("post_rst_done", done, 1);
    chk("post_rst_ops", ops, exp_b);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clr_ops", ops, 0);
    chk("restart_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Generic 8/8/2 instance: one beat completes the load
    g_start = 1'b1;
    tick();
    g_start = 1'b0;
    chk("gen_busy", g_busy, 1);
    chk("gen_done_pre", g_done, 0);
    g_valid = 1'b1; g_digits = 16'h3CA5;
    tick();
    g_valid = 1'b0;
    chk("gen_done", g_done, 1);
    chk("gen_cnt", g_cnt, 1);
    chk("gen_op0", g_ops[7:0], 8'hA5);
    chk("gen_ops", g_ops, 16'h3CA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_operand_loader.md
Name: ecc_operand_loader

Overview:
- Parametrised digit-serial operand deserializer at the front of the ECC scalar-multiplication datapath.
- Collects NUM_OPS operands (Px, Py, prime, a, k, ...) of OP_W bits each. All operands arrive in parallel, one DIG_W-bit digit per operand per accepted beat.
- Presents the assembled operands to Control with a level done / ack handshake.
- Over the previous fixed 4-bit/32-bit loader it adds: generic widths and operand count, a valid-qualified (stallable) input, abort, and done held until acknowledged.

Parameters:
OP_W, 32, operand width in bits; must be a multiple of DIG_W
DIG_W, 4, digit width per beat
NUM_OPS, 5, number of operands loaded in parallel
BEATS, OP_W/DIG_W (derived localparam), accepted beats per load; must be >= 1
CNT_W, $clog2(BEATS+1) (derived localparam), beat counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start a load; honoured only in IDLE
i_valid  in  1  i_digits carries a valid beat this cycle
i_digits  in  NUM_OPS*DIG_W  one digit per operand; operand j is at [j*DIG_W +: DIG_W]
i_ack  in  1  consumer has taken the operands; honoured only in HOLD
i_abort  in  1  cancel the load in progress; honoured only in LOAD
o_busy  out  1  high in LOAD
o_load_done  out  1  high in HOLD; o_operands are complete and stable
o_beat_cnt  out  CNT_W  beats accepted in the current load
o_operands  out  NUM_OPS*OP_W  operand j is at [j*OP_W +: OP_W]

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE. o_operands=0, o_beat_cnt=0, o_busy=0, o_load_done=0.
- States are IDLE, LOAD and HOLD.
- IDLE:
  - i_start=1: clear o_operands and o_beat_cnt, go to LOAD next cycle.
  - i_valid in the start cycle is ignored.
  - Otherwise stay; o_operands keep their previous values.
- LOAD, priority order:
  - i_abort=1: go to IDLE, clear o_operands and o_beat_cnt. Any simultaneous valid beat is discarded.
  - Else i_valid=1: write digit j into operand j at bit offset o_beat_cnt*DIG_W (LSB-first), then increment o_beat_cnt.
  - On the BEATS-th accepted beat: go to HOLD. o_load_done rises the cycle after that beat.
  - i_valid=0: hold; no timeout.
  - i_start is ignored.
- Latency: o_load_done asserts exactly one cycle after the last accepted beat. Minimum start-to-done is 1+BEATS cycles.
- HOLD:
  - o_operands are frozen and o_load_done=1.
  - i_ack=1: go to IDLE next cycle; o_load_done drops and o_operands are retained.
  - i_start, i_valid and i_abort are ignored.
- i_ack outside HOLD and i_abort outside LOAD have no effect.
- o_beat_cnt saturates at BEATS in HOLD and is cleared only by start, abort or reset.
- Reset mid-load or in HOLD returns to IDLE immediately with all outputs cleared.
- BEATS=1: the first accepted beat completes the load.

Optional Feature:
- Macro: LOADER_MSB_FIRST_EN.
- Defined: digits arrive most-significant first. Beat b writes bit offset (BEATS-1-b)*DIG_W.
- Undefined (default): LSB-first, as above.
- Handshake, counts and latency are identical in both builds.

Decomposition:
- Shared package ecc_pkg holds:
  - the state enum (IDLE/LOAD/HOLD);
  - the default OP_W, DIG_W and NUM_OPS constants;
  - the operand index constants OP_PX=0, OP_PY=1, OP_PRIME=2, OP_A=3, OP_K=4.
- One natural sub-module, digit_shift_reg: a single-operand OP_W register with clear and a write-digit-at-index input, instantiated NUM_OPS times by generate. The FSM and counter stay in the top.

Test Plan (OP_W=32, DIG_W=4, NUM_OPS=5 unless noted):
- Basic LSB-first load:
  - Stimulus: start, then 8 consecutive valid beats. Px digits 1..8; Py, prime, a, k digits all 0xF.
  - Response: o_load_done high in the cycle after beat 8. Px=0x87654321, the other operands=0xFFFFFFFF, o_beat_cnt=8. Done stays high until i_ack, then drops next cycle.
- Stalled input:
  - Stimulus: 8 beats with i_valid low for 3 cycles between beats 4 and 5.
  - Response: same operand values as the basic load; o_load_done 12 cycles after start.
- Abort:
  - Stimulus: i_abort with i_valid=1 on beat 5.
  - Response: IDLE next cycle; o_operands=0, o_beat_cnt=0, o_load_done never asserts.
- Ignored controls:
  - Stimulus: i_start during LOAD and during HOLD; i_ack during LOAD.
  - Response: no state change; the load completes normally.
- Asynchronous reset:
  - Stimulus: drop i_rst_n mid-cycle during beat 3.
  - Response: outputs cleared before the next clock edge. A new load after reset completes correctly.
- MSB-first build (LOADER_MSB_FIRST_EN):
  - Stimulus: Px digits 1..8.
  - Response: Px=0x12345678.
- Generic width (OP_W=8, DIG_W=8, NUM_OPS=2):
  - Stimulus: a single valid beat with value 0xA5 on operand 0.
  - Response: operand 0 = 0xA5; done one cycle later.
